// File: rtl/cmd_addr_sequencer_pkg.sv
// Shared ONFI state encodings, limits and command opcodes
// for the command/address sequencer.
package cmd_addr_sequencer_pkg;

   localparam logic [3:0] ST_IDLE       = 4'd0;
   localparam logic [3:0] ST_CMD1_ISSUE = 4'd1;
   localparam logic [3:0] ST_CMD1_WAIT  = 4'd2;
   localparam logic [3:0] ST_ADDR_ISSUE = 4'd3;
   localparam logic [3:0] ST_ADDR_WAIT  = 4'd4;
   localparam logic [3:0] ST_CMD2_ISSUE = 4'd5;
   localparam logic [3:0] ST_CMD2_WAIT  = 4'd6;
   localparam logic [3:0] ST_GAP        = 4'd7;
   localparam logic [3:0] ST_DONE       = 4'd8;

   localparam int MAX_ADDR_CYCLES = 5;

   localparam logic [7:0] CMD_READ      = 8'h00;
   localparam logic [7:0] CMD_READ_CONF = 8'h30;
   localparam logic [7:0] CMD_READ_ID   = 8'h90;
   localparam logic [7:0] CMD_RESET     = 8'hFF;

   function automatic logic [2:0] clamp_addr_cycles(
      input logic [2:0] n
   );
      if (n > 3'(MAX_ADDR_CYCLES))
         return 3'(MAX_ADDR_CYCLES);
      return n;
   endfunction

endpackage

// File: rtl/cmd_addr_sequencer.sv
// ONFI command/address transaction sequencer feeding the two latch units.
// Macro ONFI_CMD2_EN enables the optional second command phase.
module cmd_addr_sequencer #(
   parameter int GAP_CYCLES = 0
) (
   input  logic        clk,
   input  logic        nreset,
   input  logic        start,
   input  logic [7:0]  cmd1,
   input  logic [39:0] addr,
   input  logic [2:0]  addr_cycles,
   input  logic [7:0]  cmd2,
   input  logic        cmd2_en,
   input  logic        cmd_busy,
   input  logic        cmd_initialized,
   input  logic        addr_busy,
   input  logic        addr_initialized,
   output logic        cmd_activate,
   output logic [15:0] cmd_data,
   output logic        addr_activate,
   output logic [15:0] addr_data,
   output logic        busy,
   output logic        done
);
   import cmd_addr_sequencer_pkg::*;

   logic [3:0]  state_q, state_d;
   logic [3:0]  ret_q, ret_d;
   logic [7:0]  gap_q, gap_d;
   logic        guard_q, guard_d;
   logic [2:0]  idx_q, idx_d;
   logic [2:0]  nad_q, nad_d;
   logic [7:0]  cmd1_q, cmd1_d;
   logic [39:0] addr_q, addr_d;

   logic [3:0]  after_last, after_cmd1;
   logic [3:0]  after_addr, tgt;
   logic        leave, can_start;
   logic [39:0] addr_sh;
   logic [7:0]  cmd_byte;
   logic        in_cmd, in_addr;
   logic        cmd_iss, addr_iss;

   logic        cact_q, aact_q;
   logic [15:0] cdat_q, adat_q;
   logic        busy_q, done_q;

`ifdef ONFI_CMD2_EN
   logic [7:0]  cmd2_q, cmd2_d;
   logic        cmd2_en_q, cmd2_en_d;
   assign after_last = cmd2_en_q ? ST_CMD2_ISSUE
                                 : ST_DONE;
`else
   logic unused_cmd2;
   assign unused_cmd2 = ^{cmd2, cmd2_en};
   assign after_last  = ST_DONE;
`endif

   assign can_start = start && cmd_initialized &&
                      addr_initialized &&
                      !cmd_busy && !addr_busy;

   assign after_cmd1 = (nad_q != 3'd0) ? ST_ADDR_ISSUE
                                       : after_last;
   assign after_addr = (idx_q + 3'd1 < nad_q) ? ST_ADDR_ISSUE
                                              : after_last;

   // Phase sequencing: issue, guarded wait, optional gap, done.
   always_comb begin
      state_d = state_q;
      ret_d   = ret_q;
      gap_d   = gap_q;
      guard_d = guard_q;
      idx_d   = idx_q;
      nad_d   = nad_q;
      cmd1_d  = cmd1_q;
      addr_d  = addr_q;
`ifdef ONFI_CMD2_EN
      cmd2_d    = cmd2_q;
      cmd2_en_d = cmd2_en_q;
`endif
      leave = 1'b0;
      tgt   = ST_DONE;
      unique case (state_q)
         ST_IDLE: begin
            if (can_start) begin
               cmd1_d  = cmd1;
               addr_d  = addr;
               nad_d   = clamp_addr_cycles(addr_cycles);
               idx_d   = 3'd0;
`ifdef ONFI_CMD2_EN
               cmd2_d    = cmd2;
               cmd2_en_d = cmd2_en;
`endif
               state_d = ST_CMD1_ISSUE;
            end
         end
         ST_CMD1_ISSUE: begin
            guard_d = 1'b1;
            state_d = ST_CMD1_WAIT;
         end
         ST_CMD1_WAIT: begin
            if (guard_q) begin
               guard_d = 1'b0;
            end else if (!cmd_busy) begin
               leave = 1'b1;
               tgt   = after_cmd1;
            end
         end
         ST_ADDR_ISSUE: begin
            guard_d = 1'b1;
            state_d = ST_ADDR_WAIT;
         end
         ST_ADDR_WAIT: begin
            if (guard_q) begin
               guard_d = 1'b0;
            end else if (!addr_busy) begin
               leave = 1'b1;
               tgt   = after_addr;
               if (after_addr == ST_ADDR_ISSUE)
                  idx_d = idx_q + 3'd1;
            end
         end
`ifdef ONFI_CMD2_EN
         ST_CMD2_ISSUE: begin
            guard_d = 1'b1;
            state_d = ST_CMD2_WAIT;
         end
         ST_CMD2_WAIT: begin
            if (guard_q) begin
               guard_d = 1'b0;
            end else if (!cmd_busy) begin
               leave = 1'b1;
               tgt   = ST_DONE;
            end
         end
`endif
         ST_GAP: begin
            if (gap_q == 8'd0)
               state_d = ret_q;
            else
               gap_d = gap_q - 8'd1;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (leave) begin
         if (tgt != ST_DONE && GAP_CYCLES > 0) begin
            state_d = ST_GAP;
            ret_d   = tgt;
            gap_d   = 8'(GAP_CYCLES - 1);
         end else begin
            state_d = tgt;
         end
      end
   end

   // Byte selection and phase decode for the next cycle's outputs.
   always_comb begin
      addr_sh  = addr_d >> {idx_d, 3'b000};
      cmd_byte = cmd1_d;
`ifdef ONFI_CMD2_EN
      if (state_d == ST_CMD2_ISSUE ||
          state_d == ST_CMD2_WAIT)
         cmd_byte = cmd2_d;
`endif
      cmd_iss  = (state_d == ST_CMD1_ISSUE) ||
                 (state_d == ST_CMD2_ISSUE);
      addr_iss = (state_d == ST_ADDR_ISSUE);
      in_cmd   = cmd_iss ||
                 (state_d == ST_CMD1_WAIT) ||
                 (state_d == ST_CMD2_WAIT);
      in_addr  = addr_iss ||
                 (state_d == ST_ADDR_WAIT);
   end

   // Control and captured-transaction registers.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q <= ST_IDLE;
         ret_q   <= ST_IDLE;
         gap_q   <= 8'd0;
         guard_q <= 1'b0;
         idx_q   <= 3'd0;
         nad_q   <= 3'd0;
         cmd1_q  <= 8'h00;
         addr_q  <= 40'h0;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         gap_q   <= gap_d;
         guard_q <= guard_d;
         idx_q   <= idx_d;
         nad_q   <= nad_d;
         cmd1_q  <= cmd1_d;
         addr_q  <= addr_d;
      end
   end

`ifdef ONFI_CMD2_EN
   // Captured second command.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         cmd2_q    <= 8'h00;
         cmd2_en_q <= 1'b0;
      end else begin
         cmd2_q    <= cmd2_d;
         cmd2_en_q <= cmd2_en_d;
      end
   end
`endif

   // Registered outputs, decoded from the next state.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         cact_q <= 1'b0;
         aact_q <= 1'b0;
         cdat_q <= 16'h0000;
         adat_q <= 16'h0000;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         cact_q <= cmd_iss;
         aact_q <= addr_iss;
         cdat_q <= in_cmd ? {8'h00, cmd_byte}
                          : 16'h0000;
         adat_q <= in_addr ? {8'h00, addr_sh[7:0]}
                           : 16'h0000;
         busy_q <= (state_d != ST_IDLE);
         done_q <= (state_d == ST_DONE);
      end
   end

   assign cmd_activate  = cact_q;
   assign addr_activate = aact_q;
   assign cmd_data      = cdat_q;
   assign addr_data     = adat_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule

// File: tb/tb_cmd_addr_sequencer.sv
// Bench for cmd_addr_sequencer: two instances (gap 0 and gap 3)
// against a timeline model of expected pulses, plus literal checks.
module tb_cmd_addr_sequencer;

   localparam int LAT_C = 2;
   localparam int LAT_A = 1;

   typedef struct {
      bit         is_addr;
      logic [7:0] b;
      int         iss;
      int         wex;
   } pulse_t;

   typedef struct {
      bit          is_addr;
      logic [15:0] d;
      int          cyc;
   } obs_t;

   logic        clk;
   logic        nreset;
   logic        start;
   logic [7:0]  cmd1;
   logic [39:0] addr;
   logic [2:0]  addr_cycles;
   logic [7:0]  cmd2;
   logic        cmd2_en;
   logic        c_init;
   logic        a_init;

   int checks = 0;
   int passed = 0;
   logic [16:0] ex[$];

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act === exp)
         passed++;
      else
         $display("FAIL %s: got %0h, want %0h",
                  nm, act, exp);
   endtask

   task automatic chk_seq(input string nm,
                          input obs_t q[$],
                          input logic [16:0] e[$]);
      chk({nm, " count"}, q.size(), e.size());
      foreach (e[k])
         if (k < q.size())
            chk($sformatf("%s pulse%0d", nm, k),
                {q[k].is_addr, q[k].d}, e[k]);
   endtask

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int GAP = 3 * g;
      logic        c_act, a_act, bsy, dn;
      logic [15:0] c_dat, a_dat;
      logic        c_busy, a_busy;
      int          c_cnt = 0;
      int          a_cnt = 0;
      pulse_t      pl[$];
      obs_t        obs[$];
      int          dones[$];
      int          mcyc = 0;
      int          first_cyc = -10;
      int          done_cyc = -10;

      cmd_addr_sequencer #(.GAP_CYCLES(GAP)) u_dut (
         .clk              (clk),
         .nreset           (nreset),
         .start            (start),
         .cmd1             (cmd1),
         .addr             (addr),
         .addr_cycles      (addr_cycles),
         .cmd2             (cmd2),
         .cmd2_en          (cmd2_en),
         .cmd_busy         (c_busy),
         .cmd_initialized  (c_init),
         .addr_busy        (a_busy),
         .addr_initialized (a_init),
         .cmd_activate     (c_act),
         .cmd_data         (c_dat),
         .addr_activate    (a_act),
         .addr_data        (a_dat),
         .busy             (bsy),
         .done             (dn)
      );

      assign c_busy = (c_cnt != 0);
      assign a_busy = (a_cnt != 0);

      // Latch stand-ins: busy from one edge after activate.
      always @(posedge clk or negedge nreset) begin
         if (!nreset) begin
            c_cnt <= 0;
            a_cnt <= 0;
         end else begin
            if (c_act)          c_cnt <= LAT_C;
            else if (c_cnt > 0) c_cnt <= c_cnt - 1;
            if (a_act)          a_cnt <= LAT_A;
            else if (a_cnt > 0) a_cnt <= a_cnt - 1;
         end
      end

      // Timeline model and per-cycle compare.
      always @(posedge clk) begin : model
         pulse_t      p;
         pulse_t      nw[$];
         int          t;
         int          n;
         logic        e_ca, e_aa, e_bsy, e_dn;
         logic [15:0] e_cd, e_ad;
         mcyc++;
         if (!nreset) begin
            pl.delete();
            first_cyc = -10;
            done_cyc  = -10;
         end else if (mcyc - 1 > done_cyc && start &&
                      c_init && a_init &&
                      !c_busy && !a_busy) begin
            nw.delete();
            p.is_addr = 1'b0;
            p.b = cmd1;
            nw.push_back(p);
            n = (addr_cycles > 3'd5) ? 5 : int'(addr_cycles);
            for (int i = 0; i < n; i++) begin
               p.is_addr = 1'b1;
               p.b = addr[8*i +: 8];
               nw.push_back(p);
            end
`ifdef ONFI_CMD2_EN
            if (cmd2_en) begin
               p.is_addr = 1'b0;
               p.b = cmd2;
               nw.push_back(p);
            end
`endif
            t = mcyc;
            foreach (nw[k]) begin
               nw[k].iss = t;
               nw[k].wex = t + 1 +
                  (nw[k].is_addr ? LAT_A : LAT_C);
               t = nw[k].wex + 1 + GAP;
            end
            done_cyc  = nw[nw.size()-1].wex + 1;
            first_cyc = mcyc;
            pl = nw;
         end
         #1;
         e_ca = 1'b0;
         e_aa = 1'b0;
         e_cd = 16'h0000;
         e_ad = 16'h0000;
         foreach (pl[k]) begin
            if (pl[k].iss == mcyc) begin
               if (pl[k].is_addr) e_aa = 1'b1;
               else               e_ca = 1'b1;
            end
            if (mcyc >= pl[k].iss && mcyc <= pl[k].wex) begin
               if (pl[k].is_addr) e_ad = {8'h00, pl[k].b};
               else               e_cd = {8'h00, pl[k].b};
            end
         end
         e_bsy = (mcyc >= first_cyc) && (mcyc <= done_cyc);
         e_dn  = (mcyc == done_cyc);
         chk($sformatf("g%0d cyc%0d outputs", g, mcyc),
             {c_act, a_act, c_dat, a_dat, bsy, dn},
             {e_ca, e_aa, e_cd, e_ad, e_bsy, e_dn});
         chk($sformatf("g%0d cyc%0d excl", g, mcyc),
             c_act & a_act, 1'b0);
         if (c_act) obs.push_back('{1'b0, c_dat, mcyc});
         if (a_act) obs.push_back('{1'b1, a_dat, mcyc});
         if (dn)    dones.push_back(mcyc);
      end
   end

   task automatic clear_logs();
      g_inst[0].obs.delete();
      g_inst[1].obs.delete();
      g_inst[0].dones.delete();
      g_inst[1].dones.delete();
   endtask

   task automatic go(input logic [7:0] c1,
                     input logic [39:0] a,
                     input logic [2:0] n,
                     input logic [7:0] c2,
                     input logic en);
      cmd1 = c1;
      addr = a;
      addr_cycles = n;
      cmd2 = c2;
      cmd2_en = en;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int i;
      for (i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (!g_inst[0].bsy && !g_inst[1].bsy) break;
      end
      chk({nm, " finishes"}, i < 3000, 1'b1);
      @(negedge clk);
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, " g0"},
          {g_inst[0].c_act, g_inst[0].a_act,
           g_inst[0].c_dat, g_inst[0].a_dat,
           g_inst[0].bsy, g_inst[0].dn}, 36'h0);
      chk({nm, " g1"},
          {g_inst[1].c_act, g_inst[1].a_act,
           g_inst[1].c_dat, g_inst[1].a_dat,
           g_inst[1].bsy, g_inst[1].dn}, 36'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int i;
      nreset = 1'b0;
      start = 1'b0;
      cmd1 = 8'h00;
      addr = 40'h0;
      addr_cycles = 3'd0;
      cmd2 = 8'h00;
      cmd2_en = 1'b0;
      c_init = 1'b0;
      a_init = 1'b0;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      nreset = 1'b1;

      start = 1'b1;
      repeat (4) @(negedge clk);
      start = 1'b0;
      chk("uninit g0", g_inst[0].obs.size(), 0);
      chk("uninit g1", g_inst[1].obs.size(), 0);
      c_init = 1'b1;
      a_init = 1'b1;
      @(negedge clk);

      clear_logs();
      go(8'h00, 40'h0403020100, 3'd5, 8'h30, 1'b1);
      repeat (3) @(negedge clk);
      start = 1'b1;
      cmd1 = 8'h55;
      repeat (3) @(negedge clk);
      start = 1'b0;
      cmd1 = 8'hAA;
      wait_idle("page");
      ex.delete();
      ex.push_back(17'h0_0000);
      ex.push_back(17'h1_0000);
      ex.push_back(17'h1_0001);
      ex.push_back(17'h1_0002);
      ex.push_back(17'h1_0003);
      ex.push_back(17'h1_0004);
`ifdef ONFI_CMD2_EN
      ex.push_back(17'h0_0030);
`endif
      chk_seq("page g0", g_inst[0].obs, ex);
      chk_seq("page g1", g_inst[1].obs, ex);
      chk("page done g0", g_inst[0].dones.size(), 1);
      chk("page done g1", g_inst[1].dones.size(), 1);
      if (g_inst[0].obs.size() >= 3) begin
         chk("g0 cmd->addr spacing",
             g_inst[0].obs[1].cyc - g_inst[0].obs[0].cyc, 4);
         chk("g0 addr->addr spacing",
             g_inst[0].obs[2].cyc - g_inst[0].obs[1].cyc, 3);
      end
      if (g_inst[1].obs.size() >= 3) begin
         chk("g1 gap cmd->addr spacing",
             g_inst[1].obs[1].cyc - g_inst[1].obs[0].cyc, 7);
         chk("g1 gap addr->addr spacing",
             g_inst[1].obs[2].cyc - g_inst[1].obs[1].cyc, 6);
      end

      clear_logs();
      go(8'hFF, 40'h0, 3'd0, 8'h30, 1'b0);
      cmd1 = 8'h12;
      wait_idle("reset cmd");
      ex.delete();
      ex.push_back(17'h0_00FF);
      chk_seq("rstcmd g0", g_inst[0].obs, ex);
      chk_seq("rstcmd g1", g_inst[1].obs, ex);
      if (g_inst[1].dones.size() == 1 &&
          g_inst[1].obs.size() == 1)
         chk("g1 no gap before done",
             g_inst[1].dones[0] - g_inst[1].obs[0].cyc, 4);
      else
         chk("g1 rstcmd done count",
             g_inst[1].dones.size(), 1);

      clear_logs();
      go(8'h00, 40'hAABBCCDDEE, 3'd7, 8'h00, 1'b0);
      wait_idle("clamp");
      ex.delete();
      ex.push_back(17'h0_0000);
      ex.push_back(17'h1_00EE);
      ex.push_back(17'h1_00DD);
      ex.push_back(17'h1_00CC);
      ex.push_back(17'h1_00BB);
      ex.push_back(17'h1_00AA);
      chk_seq("clamp g0", g_inst[0].obs, ex);
      chk_seq("clamp g1", g_inst[1].obs, ex);

      clear_logs();
      cmd1 = 8'h90;
      addr = 40'h0;
      addr_cycles = 3'd1;
      cmd2_en = 1'b0;
      start = 1'b1;
      for (i = 0; i < 400; i++) begin
         if (g_inst[0].dones.size() >= 2) break;
         @(negedge clk);
      end
      start = 1'b0;
      chk("held retrigger", g_inst[0].dones.size() >= 2, 1'b1);
      if (g_inst[0].obs.size() >= 3 &&
          g_inst[0].dones.size() >= 1) begin
         chk("held second cmd",
             {g_inst[0].obs[2].is_addr, g_inst[0].obs[2].d},
             17'h0_0090);
         chk("held first idle accept",
             g_inst[0].obs[2].cyc - g_inst[0].dones[0], 2);
      end
      wait_idle("held");

      clear_logs();
      go(8'h00, 40'h0403020100, 3'd5, 8'h00, 1'b0);
      for (i = 0; i < 200; i++) begin
         if (g_inst[0].obs.size() >= 4) break;
         @(negedge clk);
      end
      chk("reach addr2", g_inst[0].obs.size(), 4);
      @(negedge clk);
      nreset = 1'b0;
      #1;
      chk_zero("mid reset");
      repeat (2) @(negedge clk);
      nreset = 1'b1;
      #1;
      chk("post reset busy g0", g_inst[0].bsy, 1'b0);
      chk("post reset busy g1", g_inst[1].bsy, 1'b0);
      @(negedge clk);

      clear_logs();
      go(8'h90, 40'h0, 3'd1, 8'h00, 1'b0);
      wait_idle("after reset");
      ex.delete();
      ex.push_back(17'h0_0090);
      ex.push_back(17'h1_0000);
      chk_seq("after reset g0", g_inst[0].obs, ex);
      chk_seq("after reset g1", g_inst[1].obs, ex);
      chk("after reset done g0", g_inst[0].dones.size(), 1);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
